// File: rtl/tcm_arbiter_pkg.sv
// Shared definitions for the two-port TCM arbiter: sequencer state encoding
// and the port indices used for ownership and round-robin history.
package tcm_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_e;

  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. Purely combinational; the caller owns the
// last-grant history and the enable that says a new command may issue.
module rr_arb2
  import tcm_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contention: favour the port that did not win last time.
        2'b11:   gnt = (last_grant == PORT_LSU) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/tcm_arbiter.sv
// Two-port arbiter/sequencer for one single-port TCM SRAM with one command
// outstanding at a time and one response per command on the owning port.
module tcm_arbiter
  import tcm_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int RAM_AW = 9
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_cmd_valid,
  output logic              m0_cmd_ready,
  input  logic              m0_cmd_read,
  input  logic [AW-1:0]     m0_cmd_addr,
  input  logic [DW-1:0]     m0_cmd_wdata,
  input  logic [MW-1:0]     m0_cmd_wmask,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [DW-1:0]     m0_rsp_rdata,

  input  logic              m1_cmd_valid,
  output logic              m1_cmd_ready,
  input  logic              m1_cmd_read,
  input  logic [AW-1:0]     m1_cmd_addr,
  input  logic [DW-1:0]     m1_cmd_wdata,
  input  logic [MW-1:0]     m1_cmd_wmask,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [DW-1:0]     m1_rsp_rdata,

  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic              ram_we,
  output logic [MW-1:0]     ram_wem,
  input  logic [DW-1:0]     ram_dout
);

  state_e              r_state;
  logic                r_owner;
  logic                r_last_grant;
  logic                r_pend_read;
  logic [RAM_AW-1:0]   r_hold_addr;

  logic                w_rsp_active;
  logic                w_owner_ready;
  logic                w_rsp_fire;
  logic                w_issue_ok;
  logic [1:0]          w_gnt;
  logic                w_issue;
  logic                w_sel;
  logic                w_sel_read;
  logic [AW-1:0]       w_sel_addr;
  logic [DW-1:0]       w_sel_wdata;
  logic [MW-1:0]       w_sel_wmask;
  logic [RAM_AW-1:0]   w_word;
  logic                w_write;
  logic [DW-1:0]       w_rdata;

  assign w_rsp_active  = (r_state == ST_RSP);
  assign w_owner_ready = (r_owner == PORT_LSU) ? m1_rsp_ready : m0_rsp_ready;
  assign w_rsp_fire    = w_rsp_active & w_owner_ready;
  // Blocking issue under reset keeps the RAM write strobe low while rst is high.
  assign w_issue_ok    = ~rst & ((r_state == ST_IDLE) | w_rsp_fire);

  rr_arb2 u_rr_arb2 (
    .req        ({m1_cmd_valid, m0_cmd_valid}),
    .last_grant (r_last_grant),
    .en         (w_issue_ok),
    .gnt        (w_gnt)
  );

  assign w_issue     = |w_gnt;
  assign w_sel       = w_gnt[1];
  assign w_sel_read  = w_sel ? m1_cmd_read  : m0_cmd_read;
  assign w_sel_addr  = w_sel ? m1_cmd_addr  : m0_cmd_addr;
  assign w_sel_wdata = w_sel ? m1_cmd_wdata : m0_cmd_wdata;
  assign w_sel_wmask = w_sel ? m1_cmd_wmask : m0_cmd_wmask;
  assign w_word      = w_sel_addr[RAM_AW+1:2];
  assign w_write     = w_issue & ~w_sel_read;

  logic w_unused;
  assign w_unused = &{1'b0, w_sel_addr[AW-1:RAM_AW+2], w_sel_addr[1:0]};

  assign m0_cmd_ready = w_gnt[0];
  assign m1_cmd_ready = w_gnt[1];

  // Idle cycles re-present the last read address so ram_dout stays put.
  assign ram_addr = w_issue ? w_word : r_hold_addr;
  assign ram_we   = w_write;
  assign ram_wem  = w_write ? w_sel_wmask : '0;
  assign ram_din  = w_sel_wdata;

  assign w_rdata      = r_pend_read ? ram_dout : '0;
  assign m0_rsp_valid = w_rsp_active & (r_owner == PORT_IFU);
  assign m1_rsp_valid = w_rsp_active & (r_owner == PORT_LSU);
  assign m0_rsp_rdata = m0_rsp_valid ? w_rdata : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? w_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= PORT_IFU;
      r_last_grant <= PORT_LSU;
      r_pend_read  <= 1'b0;
      r_hold_addr  <= '0;
    end else if (w_issue) begin
      r_state      <= ST_RSP;
      r_owner      <= w_sel;
      r_last_grant <= w_sel;
      r_pend_read  <= w_sel_read;
      if (w_sel_read) begin
        r_hold_addr <= w_word;
      end
    end else if (w_rsp_fire) begin
      r_state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Bench for tcm_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter and a shadow memory.
module tb_tcm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
  logic [31:0] m0_cmd_addr, m0_cmd_wdata;
  logic [3:0]  m0_cmd_wmask;
  logic        m0_rsp_valid, m0_rsp_ready;
  logic [31:0] m0_rsp_rdata;
  logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
  logic [31:0] m1_cmd_addr, m1_cmd_wdata;
  logic [3:0]  m1_cmd_wmask;
  logic        m1_rsp_valid, m1_rsp_ready;
  logic [31:0] m1_rsp_rdata;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram_mem [0:511];
  logic [31:0] ref_mem [0:511];

  always #5 clk = ~clk;

  tcm_arbiter #(.AW(32), .DW(32), .MW(4), .RAM_AW(9)) dut (
    .clk(clk), .rst(rst),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_wem(ram_wem),
    .ram_dout(ram_dout)
  );

  // Single-port SRAM: a cycle without ram_we is a read; output held otherwise.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_cmd_valid = 0; m0_cmd_read = 0; m0_cmd_addr = 0; m0_cmd_wdata = 0; m0_cmd_wmask = 0;
    m1_cmd_valid = 0; m1_cmd_read = 0; m1_cmd_addr = 0; m1_cmd_wdata = 0; m1_cmd_wmask = 0;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h10;
    m1_cmd_valid = 1; m1_cmd_read = 0; m1_cmd_addr = 32'h20; m1_cmd_wmask = 4'hF;
    tick(); tick(); #2;
    n_tests++;
    if ({m0_rsp_valid, m1_rsp_valid, m0_cmd_ready, m1_cmd_ready, ram_we, ram_wem} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rv0=%b rv1=%b cr0=%b cr1=%b we=%b wem=%h, want all 0",
               m0_rsp_valid, m1_rsp_valid, m0_cmd_ready, m1_cmd_ready, ram_we, ram_wem);
    end
    n_tests++;
    if (ram_addr !== 9'd0) begin
      n_fail++; $display("FAIL reset_addr: got %0d want 0", ram_addr);
    end
    idle_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_read;
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h0000_0010;
    #2;
    n_tests++;
    if ({m0_cmd_ready, m1_cmd_ready, ram_we, ram_addr} !== {3'b100, 9'd4}) begin
      n_fail++;
      $display("FAIL read_issue: got cr0=%b cr1=%b we=%b addr=%0d want 1 0 0 4",
               m0_cmd_ready, m1_cmd_ready, ram_we, ram_addr);
    end
    tick();
    m0_cmd_valid = 0; #2;
    n_tests++;
    if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_rsp: got rv0=%b rv1=%b rdata=%h want 1 0 deadbeef",
               m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata);
    end
    $display("[TB] m0 read word 4 -> %h", m0_rsp_rdata);
    tick();
  endtask

  task automatic test_write_read;
    m1_cmd_valid = 1; m1_cmd_read = 0; m1_cmd_addr = 32'h8;
    m1_cmd_wdata = 32'h11223344; m1_cmd_wmask = 4'b0011;
    #2;
    n_tests++;
    if ({m1_cmd_ready, ram_we, ram_wem, ram_addr, ram_din} !== {2'b11, 4'b0011, 9'd2, 32'h11223344}) begin
      n_fail++;
      $display("FAIL write_issue: got cr1=%b we=%b wem=%b addr=%0d din=%h", m1_cmd_ready,
               ram_we, ram_wem, ram_addr, ram_din);
    end
    ref_mem[2] = merge(ref_mem[2], 32'h11223344, 4'b0011);
    tick();
    m1_cmd_read = 1; #2;
    n_tests++;
    if ({m1_rsp_valid, m1_rsp_rdata, m1_cmd_ready, ram_we} !== {1'b1, 32'h0, 2'b10}) begin
      n_fail++;
      $display("FAIL write_rsp: got rv1=%b rdata=%h cr1=%b we=%b want 1 0 1 0",
               m1_rsp_valid, m1_rsp_rdata, m1_cmd_ready, ram_we);
    end
    tick();
    m1_cmd_valid = 0; #2;
    n_tests++;
    if ({m1_rsp_valid, m1_rsp_rdata} !== {1'b1, 32'hAABB3344}) begin
      n_fail++;
      $display("FAIL write_readback: got rv1=%b rdata=%h want 1 aabb3344", m1_rsp_valid, m1_rsp_rdata);
    end
    $display("[TB] m1 write/read word 2 -> %h", m1_rsp_rdata);
    tick();
  endtask

  task automatic test_back_to_back;
    logic        exp_port;
    logic        prev_port;
    logic [31:0] prev_data;
    logic [8:0]  w0, w1;
    exp_port = 1'b0;   // m1 won the previous contention-free grant
    prev_port = 1'b0; prev_data = '0;
    for (int i = 0; i < 6; i++) begin
      m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = $urandom();
      m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = $urandom();
      w0 = m0_cmd_addr[10:2]; w1 = m1_cmd_addr[10:2];
      #2;
      n_tests++;
      if ({m1_cmd_ready, m0_cmd_ready, ram_addr} !== {exp_port, ~exp_port, exp_port ? w1 : w0}) begin
        n_fail++;
        $display("FAIL b2b_grant[%0d]: got cr1=%b cr0=%b addr=%0d want port%0d addr=%0d", i,
                 m1_cmd_ready, m0_cmd_ready, ram_addr, exp_port, exp_port ? w1 : w0);
      end
      if (i > 0) begin
        n_tests++;
        if ({m1_rsp_valid, m0_rsp_valid} !== {prev_port, ~prev_port} ||
            (prev_port ? m1_rsp_rdata : m0_rsp_rdata) !== prev_data) begin
          n_fail++;
          $display("FAIL b2b_rsp[%0d]: got rv1=%b rv0=%b rdata=%h want port%0d rdata=%h", i,
                   m1_rsp_valid, m0_rsp_valid, prev_port ? m1_rsp_rdata : m0_rsp_rdata,
                   prev_port, prev_data);
        end
      end
      prev_port = exp_port;
      prev_data = ref_mem[exp_port ? w1 : w0];
      $display("[TB] b2b grant port%0d word %0d", exp_port, exp_port ? w1 : w0);
      exp_port = ~exp_port;
      tick();
    end
    m0_cmd_valid = 0; m1_cmd_valid = 0; #2;
    n_tests++;
    if ({m1_rsp_valid, m0_rsp_valid} !== {prev_port, ~prev_port} ||
        (prev_port ? m1_rsp_rdata : m0_rsp_rdata) !== prev_data) begin
      n_fail++;
      $display("FAIL b2b_last_rsp: got rv1=%b rv0=%b want port%0d rdata=%h",
               m1_rsp_valid, m0_rsp_valid, prev_port, prev_data);
    end
    tick();
  endtask

  task automatic test_stall;
    logic [31:0] exp_data, wd;
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h14;
    #2;
    n_tests++;
    if (m0_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_issue: got cr0=%b want 1", m0_cmd_ready);
    end
    exp_data = ref_mem[5];
    tick();
    wd = $urandom();
    m0_cmd_valid = 0; m0_rsp_ready = 0;
    m1_cmd_valid = 1; m1_cmd_read = 0; m1_cmd_addr = 32'h14; m1_cmd_wdata = wd; m1_cmd_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_tests++;
      if ({m0_rsp_valid, m0_rsp_rdata, m1_cmd_ready, ram_we, ram_addr} !==
          {1'b1, exp_data, 2'b00, 9'd5}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got rv0=%b rdata=%h cr1=%b we=%b addr=%0d want 1 %h 0 0 5",
                 i, m0_rsp_valid, m0_rsp_rdata, m1_cmd_ready, ram_we, ram_addr, exp_data);
      end
      tick();
    end
    m0_rsp_ready = 1; #2;
    n_tests++;
    if ({m0_rsp_rdata, m1_cmd_ready, ram_we, ram_addr} !== {exp_data, 2'b11, 9'd5}) begin
      n_fail++;
      $display("FAIL stall_release: got rdata=%h cr1=%b we=%b addr=%0d want %h 1 1 5",
               m0_rsp_rdata, m1_cmd_ready, ram_we, ram_addr, exp_data);
    end
    ref_mem[5] = merge(ref_mem[5], wd, 4'hF);
    tick();
    m1_cmd_valid = 0; #2;
    n_tests++;
    if ({m1_rsp_valid, m0_rsp_valid, m1_rsp_rdata} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL stall_wrsp: got rv1=%b rv0=%b rdata=%h want 1 0 0", m1_rsp_valid,
               m0_rsp_valid, m1_rsp_rdata);
    end
    $display("[TB] stall done, m1 wrote word 5 = %h", wd);
    tick();
  endtask

  task automatic test_wrap;
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h0000_0804;
    #2;
    n_tests++;
    if ({m0_cmd_ready, ram_addr} !== {1'b1, 9'd1}) begin
      n_fail++; $display("FAIL wrap_addr: got cr0=%b addr=%0d want 1 1", m0_cmd_ready, ram_addr);
    end
    tick();
    m0_cmd_valid = 0; #2;
    n_tests++;
    if (m0_rsp_rdata !== ref_mem[1]) begin
      n_fail++; $display("FAIL wrap_rdata: got %h want %h", m0_rsp_rdata, ref_mem[1]);
    end
    $display("[TB] wrap read 0x804 -> word %0d", ram_addr);
    tick();
  endtask

  task automatic test_reset_mid;
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h20;
    tick();
    m0_cmd_valid = 0; m0_rsp_ready = 0;
    m1_cmd_valid = 1; m1_cmd_read = 0; m1_cmd_addr = 32'h20;
    m1_cmd_wdata = 32'hCAFEF00D; m1_cmd_wmask = 4'hF;
    #2;
    n_tests++;
    if (m0_rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got rv0=%b want 1", m0_rsp_valid);
    end
    rst = 1; m0_rsp_ready = 1; #1;
    n_tests++;
    if ({m0_rsp_valid, m1_rsp_valid, ram_we, m1_cmd_ready} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got rv0=%b rv1=%b we=%b cr1=%b want 0", m0_rsp_valid,
               m1_rsp_valid, ram_we, m1_cmd_ready);
    end
    tick();
    rst = 0;
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h20;
    m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 32'h24;
    #2;
    n_tests++;
    if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_grant: got cr0=%b cr1=%b want 1 0", m0_cmd_ready, m1_cmd_ready);
    end
    tick();
    m0_cmd_valid = 0; m1_cmd_valid = 0; #2;
    n_tests++;
    if (m0_rsp_rdata !== ref_mem[8]) begin
      n_fail++; $display("FAIL rstmid_nowrite: got %h want %h", m0_rsp_rdata, ref_mem[8]);
    end
    $display("[TB] reset mid-op, word 8 = %h", m0_rsp_rdata);
    tick();
  endtask

  // Transaction-level model: one outstanding command, round-robin on contention.
  task automatic test_random;
    logic        m_pending, m_port, m_last, fire, can, g_any, g;
    logic [31:0] m_data;
    logic [8:0]  m_hold, word;
    logic        c_read;
    logic [31:0] c_wdata;
    logic [3:0]  c_wmask;
    rst = 1; idle_inputs(); tick(); rst = 0;
    m_pending = 0; m_port = 0; m_last = 1; m_data = 0; m_hold = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      m0_cmd_valid = 1'($urandom_range(0, 1)); m0_cmd_read = 1'($urandom_range(0, 1));
      m0_cmd_addr = $urandom(); m0_cmd_wdata = $urandom(); m0_cmd_wmask = 4'($urandom());
      m1_cmd_valid = 1'($urandom_range(0, 1)); m1_cmd_read = 1'($urandom_range(0, 1));
      m1_cmd_addr = $urandom(); m1_cmd_wdata = $urandom(); m1_cmd_wmask = 4'($urandom());
      m0_rsp_ready = ($urandom_range(0, 3) != 0); m1_rsp_ready = ($urandom_range(0, 3) != 0);
      #2;
      n_tests++;
      if ({m1_rsp_valid, m0_rsp_valid} !== {m_pending & m_port, m_pending & ~m_port} ||
          (m_pending && (m_port ? m1_rsp_rdata : m0_rsp_rdata) !== m_data)) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got rv1=%b rv0=%b rdata=%h want pend=%b port%0d rdata=%h",
                 cyc, m1_rsp_valid, m0_rsp_valid, m_port ? m1_rsp_rdata : m0_rsp_rdata,
                 m_pending, m_port, m_data);
      end
      fire  = m_pending & (m_port ? m1_rsp_ready : m0_rsp_ready);
      can   = ~m_pending | fire;
      g_any = can & (m0_cmd_valid | m1_cmd_valid);
      g     = (m0_cmd_valid & m1_cmd_valid) ? ~m_last : m1_cmd_valid;
      n_tests++;
      if ({m1_cmd_ready, m0_cmd_ready} !== {g_any & g, g_any & ~g}) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: got cr1=%b cr0=%b want cr1=%b cr0=%b", cyc,
                 m1_cmd_ready, m0_cmd_ready, g_any & g, g_any & ~g);
      end
      if (g_any) begin
        word    = g ? m1_cmd_addr[10:2] : m0_cmd_addr[10:2];
        c_read  = g ? m1_cmd_read : m0_cmd_read;
        c_wdata = g ? m1_cmd_wdata : m0_cmd_wdata;
        c_wmask = g ? m1_cmd_wmask : m0_cmd_wmask;
        n_tests++;
        if ({ram_addr, ram_we, ram_wem} !== {word, ~c_read, c_read ? 4'h0 : c_wmask} ||
            (!c_read && ram_din !== c_wdata)) begin
          n_fail++;
          $display("FAIL rand_ram[%0d]: got addr=%0d we=%b wem=%h din=%h want %0d %b %h %h", cyc,
                   ram_addr, ram_we, ram_wem, ram_din, word, ~c_read,
                   c_read ? 4'h0 : c_wmask, c_wdata);
        end
        if (c_read) begin
          m_data = ref_mem[word];
          m_hold = word;
        end else begin
          ref_mem[word] = merge(ref_mem[word], c_wdata, c_wmask);
          m_data = '0;
        end
        m_pending = 1; m_port = g; m_last = g;
        $display("[TB] rand issue port%0d %s word %0d", g, c_read ? "rd" : "wr", word);
      end else begin
        n_tests++;
        if ({ram_we, ram_wem, ram_addr} !== {5'b0, m_hold}) begin
          n_fail++;
          $display("FAIL rand_idle[%0d]: got we=%b wem=%h addr=%0d want 0 0 %0d", cyc,
                   ram_we, ram_wem, ram_addr, m_hold);
        end
        if (fire) m_pending = 0;
      end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = {16'(i * 7 + 3), 16'(~i)};
    end
    ram_mem[4] = 32'hDEADBEEF;
    ram_mem[2] = 32'hAABBCCDD;
    for (int i = 0; i < 512; i++) ref_mem[i] = ram_mem[i];
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcm_arbiter.md
Name: tcm_arbiter

Overview:
- Two-port arbiter and sequencer for one single-port TCM SRAM (1-cycle read latency, read data held until the next read).
- Port m0 is the instruction-fetch side; port m1 is the load/store side.
- Accepts valid/ready commands from both ports, arbitrates round-robin, and drives the RAM address/data/write controls.
- Returns one response per command on the owning port's response channel.

Parameters:
- AW, 32, requester byte-address width
- DW, 32, data width
- MW, 4, write-mask width (one bit per byte)
- RAM_AW, 9, RAM word-address width (depth 512)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m0_cmd_valid  in  1  port 0 command valid
- m0_cmd_ready  out  1  port 0 command accepted
- m0_cmd_read  in  1  1 = read, 0 = write
- m0_cmd_addr  in  AW  byte address
- m0_cmd_wdata  in  DW  write data
- m0_cmd_wmask  in  MW  byte enables
- m0_rsp_valid  out  1  port 0 response valid
- m0_rsp_ready  in  1  port 0 response accepted
- m0_rsp_rdata  out  DW  read data; 0 for write responses
- m1_*  same set as m0_* for port 1
- ram_addr  out  RAM_AW  RAM word address
- ram_din  out  DW  RAM write data
- ram_we  out  1  RAM write enable; the RAM treats every cycle with ram_we=0 as a read and latches ram_addr
- ram_wem  out  MW  RAM byte mask
- ram_dout  in  DW  RAM read data (valid the cycle after the read)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - state = IDLE, owner = 0, last_grant = 1 (so m0 wins first), hold_addr = 0, pend_read = 0.
  - Outputs: rsp_valid = 0 on both ports, ram_we = 0, ram_wem = 0, ram_addr = 0.
- Word address: word = cmd_addr[RAM_AW+1:2]. Upper bits and low bits [1:0] are ignored, so addresses wrap modulo depth.
- Issue condition: issue_ok = (state==IDLE) | (state==RSP & rsp_fire), where rsp_fire = owner's rsp_valid & rsp_ready.
  - At most one command outstanding.
  - Back-to-back throughput is 1 transaction per cycle when rsp_ready stays high.
- Arbitration, combinational, only when issue_ok:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port != last_grant.
  - The granted port's cmd_ready = 1; the other port's cmd_ready = 0. No cmd_ready when !issue_ok.
  - The grant never depends on cmd_ready.
- Issue cycle (cmd_valid & cmd_ready):
  - ram_addr = word, ram_we = ~cmd_read, ram_wem = cmd_wmask (forced 0 for reads), ram_din = cmd_wdata.
  - Registered: owner = granted port, last_grant = granted port, pend_read = cmd_read, state = RSP.
  - On a read, hold_addr = word.
- Non-issue cycles:
  - ram_we = 0, ram_wem = 0, ram_addr = hold_addr.
  - The RAM re-latches the last read address, so the RAM output for the last read is never disturbed by idle cycles.
- RSP state:
  - Owner's rsp_valid = 1. rsp_rdata = ram_dout if pend_read, else 0.
  - The non-owner's rsp_valid = 0.
  - rsp_valid holds and rdata stays stable until rsp_ready.
  - On rsp_fire with no new issue: state goes to IDLE.
  - On rsp_fire with a new issue: stay in RSP with the new owner.
- Read latency: command accept at cycle N gives rsp_valid at N+1.
- Write to the address held in hold_addr: issued only on rsp_fire, so any pending read response is already consumed. Later idle cycles show the new contents on ram_dout, which no response uses.
- Simultaneous events:
  - Both ports valid in the same cycle: round-robin as above.
  - A requester may drop cmd_valid before it is granted; nothing is latched.
- Reset mid-operation: a pending response is discarded and no RAM write occurs while rst is high.

Decomposition:
- Shared package: state encoding (IDLE = 1'b0, RSP = 1'b1) and port-index constants (PORT_IFU = 0, PORT_LSU = 1).
- One sub-module, rr_arb2: 2-requester round-robin grant.
  - Inputs: req[1:0], last_grant, en.
  - Output: one-hot gnt[1:0].
  - Purely combinational; last_grant is stored in tcm_arbiter.

Test Plan:
1. Reset then m0 read 0x0000_0010 (RAM word 4 = 0xDEADBEEF):
   - Required: ram_addr = 4 and ram_we = 0 at N; m0_rsp_valid = 1 and m0_rsp_rdata = 0xDEADBEEF at N+1.
2. m1 write 0x0000_0008, wdata 0x11223344, wmask 4'b0011, then m1 read 0x8 (word 2 initially 0xAABBCCDD):
   - Required: write response rdata = 0; read returns 0xAABB3344.
3. Both ports request reads every cycle with rsp_ready = 1 for 6 cycles:
   - Required: grants alternate m0, m1, m0, …; each response arrives 1 cycle after its grant on the correct port.
4. m0 read word 5, hold m0_rsp_ready = 0 for 4 cycles while m1 holds cmd_valid:
   - Required: m0_rsp_rdata stable; m1_cmd_ready = 0; ram_addr = 5 and ram_we = 0 each cycle.
   - When rsp_ready rises: m1 is granted that same cycle.
5. Address wrap: read 0x0000_0804 with RAM_AW = 9:
   - Required: ram_addr = 1.
6. Assert rst while in RSP with m1 write valid:
   - Required: rsp_valid = 0, ram_we = 0 immediately; after release m0 wins a simultaneous request.
